// File: rtl/fp_pkg.sv
// Shared FP32 types, constants and the dot-product FSM state encoding.
package fp_pkg;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
    } fp32_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} dot_state_t;

    // Any value with an all-zero magnitude field behaves as zero.
    function automatic logic is_zero(input fp32_t x);
        return {x.e, x.m} == 31'd0;
    endfunction

endpackage

// File: rtl/fp_add.sv
// Combinational FP32 add: align by truncation, exact cancellation yields +0.
module fp_add
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    fp32_t       fa, fb, big, sml, fr;
    logic [7:0]  sh;
    logic [23:0] mb, ms, mdif, mnorm;
    logic [24:0] msum;
    logic [4:0]  lz;
    logic        unused_mnorm;

    assign unused_mnorm = mnorm[23];

    always_comb begin
        fa   = a;
        fb   = b;
        big  = ({fb.e, fb.m} > {fa.e, fa.m}) ? fb : fa;
        sml  = ({fb.e, fb.m} > {fa.e, fa.m}) ? fa : fb;
        sh   = big.e - sml.e;
        mb   = {1'b1, big.m};
        ms   = {1'b1, sml.m} >> sh;
        msum = {1'b0, mb} + {1'b0, ms};
        mdif = mb - ms;
        lz   = '0;
        // Highest set bit is visited last, so it sets the leading-zero count.
        for (int i = 0; i < 24; i++) begin
            if (mdif[i]) lz = 5'(23 - i);
        end
        mnorm = mdif << lz;
        fr.s  = big.s;
        if (big.s == sml.s) begin
            fr.e = msum[24] ? big.e + 8'd1 : big.e;
            fr.m = msum[24] ? msum[23:1] : msum[22:0];
        end else begin
            fr.e = big.e - 8'(lz);
            fr.m = mnorm[22:0];
        end
        if (big.s != sml.s && mdif == '0) fr = FP_ZERO;
        if (is_zero(fb))      fr = fa;
        else if (is_zero(fa)) fr = fb;
        sum = fr;
    end

endmodule

// File: rtl/fp_mul.sv
// Combinational FP32 multiply: sign XOR, truncated mantissa, no NaN/Inf handling.
module fp_mul
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    fp32_t       fa, fb, fr;
    logic [47:0] mp;
    logic [7:0]  ep;
    logic        unused_mp;

    assign unused_mp = ^mp[22:0];

    always_comb begin
        fa   = a;
        fb   = b;
        mp   = 48'({1'b1, fa.m}) * 48'({1'b1, fb.m});
        ep   = fa.e + fb.e - 8'd127 + 8'(mp[47]);
        fr.s = fa.s ^ fb.s;
        fr.e = ep;
        fr.m = mp[47] ? mp[46:24] : mp[45:23];
        if (is_zero(fa) || is_zero(fb)) begin
            fr.e = '0;
            fr.m = '0;
        end
        p = fr;
    end

endmodule

// File: rtl/fp_dot_accum.sv
// Streaming FP32 dot product: one product register feeding a running-sum accumulator.
module fp_dot_accum
    import fp_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             busy,
    output logic             done,
    output logic [31:0]      res
);
    dot_state_t       state;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      prod_q, acc, mul_out, add_out;
    logic             prod_vld;

    fp_mul u_mul (.a(a), .b(b), .p(mul_out));
    fp_add u_add (.a(acc), .b(prod_q), .sum(add_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            prod_q    <= FP_ZERO;
            prod_vld  <= 1'b0;
            acc       <= FP_ZERO;
            in_rdy    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res       <= FP_ZERO;
        end else begin
            done     <= 1'b0;
            prod_vld <= 1'b0;
            if (prod_vld) acc <= add_out;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        acc       <= FP_ZERO;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            state <= FLUSH;
                        end else begin
                            state  <= ACCUM;
                            in_rdy <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_vld && in_rdy) begin
                        prod_q    <= mul_out;
                        prod_vld  <= 1'b1;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state  <= FLUSH;
                            in_rdy <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // No new products enter here, so the pipe drains on this edge;
                    // take the sum that lands on the same edge.
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    res   <= prod_vld ? add_out : acc;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_dot_accum.sv
// Scoreboard bench for fp_dot_accum with a value-level truncating FP32 reference model.
module tb_fp_dot_accum;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_vld = 1'b0;
    logic [31:0]      a = '0;
    logic [31:0]      b = '0;
    logic             in_rdy, busy, done;
    logic [31:0]      res;

    fp_dot_accum #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_vld(in_vld),
        .in_rdy(in_rdy), .a(a), .b(b), .busy(busy), .done(done), .res(res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ndone = 0;
    logic [31:0] last_exp = '0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference arithmetic: a value is m * 2**e with an exact integer m; results are
    // cut back to 24 significant bits by truncation.
    function automatic logic [31:0] m_pack(input bit s, input longint m, input int e);
        logic [31:0] r;
        if (m == 0) return 32'h0;
        while (m >= 64'sd16777216) begin
            m = m >>> 1;
            e++;
        end
        while (m < 64'sd8388608) begin
            m = m <<< 1;
            e--;
        end
        r[31]    = s;
        r[30:23] = 8'(e + 150);
        r[22:0]  = 23'(m);
        return r;
    endfunction

    function automatic void m_unpack(input logic [31:0] x, output bit s, output longint m,
                                     output int e);
        s = x[31];
        m = longint'({1'b1, x[22:0]});
        e = int'(x[30:23]) - 150;
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] y);
        bit sx, sy;
        longint mx, my;
        int ex, ey;
        if (x[30:0] == 0 || y[30:0] == 0) return {x[31] ^ y[31], 31'b0};
        m_unpack(x, sx, mx, ex);
        m_unpack(y, sy, my, ey);
        return m_pack(sx ^ sy, mx * my, ex + ey);
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] acc, input logic [31:0] p);
        logic [31:0] big, sml;
        bit sb_, ss;
        longint mb, ms, m;
        int eb, es, sh;
        if (p[30:0] == 0) return acc;
        if (acc[30:0] == 0) return p;
        big = (acc[30:0] >= p[30:0]) ? acc : p;
        sml = (acc[30:0] >= p[30:0]) ? p : acc;
        m_unpack(big, sb_, mb, eb);
        m_unpack(sml, ss, ms, es);
        sh = eb - es;
        ms = (sh >= 62) ? 0 : (ms >>> sh);
        m  = (sb_ == ss) ? mb + ms : mb - ms;
        if (m == 0) return 32'h0;
        return m_pack(sb_, m, eb);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r[31]    = 1'($urandom_range(0, 1));
        r[30:23] = 8'($urandom_range(120, 134));
        r[22:0]  = 23'($urandom);
        if ($urandom_range(0, 15) == 0) r[30:0] = '0;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res", res, e.res);
                check("done_cycle", 32'(cyc), 32'(e.due));
                check("busy_at_done", 32'(busy), 32'd0);
                last_exp = e.res;
                ndone++;
            end
        end
    end

    task automatic run_vec(input int n, input logic [31:0] va[$], input logic [31:0] vb[$],
                           input bit use_lit, input logic [31:0] lit, input int gap_pct,
                           input logic [7:0] pat, input int pat_len, input int abort_at,
                           input int restart_at);
        logic [31:0] expv;
        exp_t        e;
        int          k, t_last, budget, s_cyc, nd0, idx;
        bit          restarted;
        expv = 32'h0;
        for (int i = 0; i < n; i++) expv = m_add(expv, m_mul(va[i], vb[i]));
        if (use_lit) expv = lit;
        k         = 0;
        t_last    = 0;
        idx       = 0;
        restarted = 1'b0;
        budget    = 4 * n + 50;
        nd0       = ndone;
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = LEN_W'(n);
        s_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        while (k < n && budget > 0) begin
            if (abort_at >= 0 && k == abort_at) begin
                rst_n  = 1'b0;
                in_vld = 1'b0;
                #1;
                check("abort_in_rdy", 32'(in_rdy), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_res", res, 32'h0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                repeat (8) @(posedge clk);
                #1;
                check("abort_no_done", 32'(ndone), 32'(nd0));
                return;
            end
            if (pat_len > 0 && idx < pat_len) in_vld = pat[idx];
            else in_vld = ($urandom_range(0, 99) >= gap_pct);
            idx++;
            a = in_vld ? va[k] : rand_fp();
            b = in_vld ? vb[k] : rand_fp();
            if (k == restart_at && !restarted) begin
                start     = 1'b1;
                len       = LEN_W'($urandom_range(1, 200));
                restarted = 1'b1;
            end
            if (in_vld && in_rdy) begin
                t_last = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            budget--;
        end
        in_vld = 1'b0;
        if (k < n) begin
            check("feed_timeout", 32'(k), 32'(n));
            return;
        end
        e.res = expv;
        e.due = (n == 0) ? s_cyc + 2 : t_last + 2;
        sb.push_back(e);
        for (int w = 0; w < 40 && ndone == nd0; w++) begin
            @(negedge clk);
            if (n == 0 && ndone == nd0) check("in_rdy_len0", 32'(in_rdy), 32'd0);
        end
        if (ndone == nd0) begin
            check("done_timeout", 32'(ndone), 32'(nd0 + 1));
        end else begin
            repeat (4) @(posedge clk);
            #1;
            check("res_hold", res, last_exp);
        end
    endtask

    initial begin
        logic [31:0] qa[$], qb[$];
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", res, 32'h0);
        rst_n = 1'b1;

        qa = '{32'h3F800000, 32'h40400000};
        qb = '{32'h40000000, 32'h3F000000};
        run_vec(2, qa, qb, 1, 32'h40600000, 0, 8'h00, 0, -1, -1);

        qa = {};
        qb = {};
        run_vec(0, qa, qb, 1, 32'h00000000, 0, 8'h00, 0, -1, -1);

        qa = '{32'h40000000, 32'h40000000, 32'h40000000};
        qb = '{32'h40000000, 32'h40000000, 32'h40000000};
        run_vec(3, qa, qb, 1, 32'h41400000, 0, 8'h19, 5, -1, -1);

        qa = '{32'hBF800000, 32'h40800000};
        qb = '{32'h40800000, 32'h3F800000};
        run_vec(2, qa, qb, 1, 32'h00000000, 0, 8'h00, 0, -1, -1);

        qa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        qb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        run_vec(4, qa, qb, 0, 32'h0, 0, 8'h00, 0, 2, -1);
        qa = '{32'h3F800000};
        qb = '{32'h3F800000};
        run_vec(1, qa, qb, 1, 32'h3F800000, 0, 8'h00, 0, -1, -1);

        for (int v = 0; v < 20; v++) begin
            n  = $urandom_range(1, 12);
            qa = {};
            qb = {};
            for (int i = 0; i < n; i++) begin
                qa.push_back(rand_fp());
                qb.push_back(rand_fp());
            end
            run_vec(n, qa, qb, 0, 32'h0, 30, 8'h00, 0, -1, (v % 4 == 0) ? 1 : -1);
        end

        n  = 255;
        qa = {};
        qb = {};
        for (int i = 0; i < n; i++) begin
            qa.push_back(rand_fp());
            qb.push_back(rand_fp());
        end
        run_vec(n, qa, qb, 0, 32'h0, 20, 8'h00, 0, -1, 7);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
